jacobi2d_unrolled_4_scheduler: RTL



---
 rtl/jacobi2d_unrolled_4_scheduler_if.sv | 26 ++
 rtl/jacobi2d_unrolled_4_scheduler.sv | 128 ++++++++++++
 2 files changed

// File: rtl/jacobi2d_unrolled_4_scheduler_if.sv
// Handshake bundle between the Jacobi 2D pipeline top and its loop-nest scheduler.
// The top (master) drives start/stall; the scheduler (slave) drives fires, indices and status.
interface jacobi2d_unrolled_4_scheduler_if #(
  parameter int IDX_W = 16
);
  logic             start;
  logic             stall;
  logic             t1_en;
  logic [IDX_W-1:0] t1_row;
  logic [IDX_W-1:0] t1_col;
  logic             jac_en;
  logic [IDX_W-1:0] jac_row;
  logic [IDX_W-1:0] jac_col;
  logic             busy;
  logic             done;

  modport master (
    output start, stall,
    input  t1_en, t1_row, t1_col, jac_en, jac_row, jac_col, busy, done
  );

  modport slave (
    input  start, stall,
    output t1_en, t1_row, t1_col, jac_en, jac_row, jac_col, busy, done
  );
endinterface

// File: rtl/jacobi2d_unrolled_4_scheduler.sv
// Bounded, stallable loop-nest sequencer for the unrolled-by-4 Jacobi 2D pipeline:
// fires t1_update_0 for N cycles and the stencil op DELAY cycles behind it, then pulses done.
module jacobi2d_unrolled_4_scheduler #(
  parameter int ROWS       = 64,
  parameter int COL_GROUPS = 16,
  parameter int DELAY      = 33,
  parameter int IDX_W      = 16,
  parameter int CNT_W      = 32
) (
  input  logic clk,
  input  logic rst,
  jacobi2d_unrolled_4_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] N_C      = CNT_W'(ROWS * COL_GROUPS);
  localparam logic [CNT_W-1:0] D_C      = CNT_W'(DELAY);
  localparam logic [CNT_W-1:0] L_C      = N_C + D_C;
  localparam logic [CNT_W-1:0] L_LAST   = L_C - CNT_W'(1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COL_GROUPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_t;
  logic             r_done;
  logic             w_start_run;
  logic             w_finish;
  logic             w_advance;
  logic             w_jac_started;
  logic             w_t1_fire;
  logic             w_jac_fire;
  logic             w_fire [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = RUN;
          w_start_run  = 1'b1;
        end
      end
      RUN: begin
        if (!bus.stall && (r_t == L_LAST)) begin
          w_state_next = IDLE;
          w_finish     = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A zero DELAY would make the lower bound an always-true unsigned compare.
  generate
    if (DELAY == 0) begin : g_no_delay
      assign w_jac_started = 1'b1;
    end else begin : g_delay
      assign w_jac_started = (r_t >= D_C);
    end
  endgenerate

  assign w_advance  = (r_state == RUN) && !bus.stall;
  assign w_t1_fire  = w_advance && (r_t < N_C);
  assign w_jac_fire = w_advance && w_jac_started && (r_t < L_C);
  assign w_fire[0]  = w_t1_fire;
  assign w_fire[1]  = w_jac_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start_run) begin
        r_t <= '0;
      end else if (w_advance) begin
        r_t <= r_t + CNT_W'(1);
      end
    end
  end

  // Index pair 0 follows t1, pair 1 follows the stencil op; each moves only on its own fire.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_idx
      logic [IDX_W-1:0] r_row;
      logic [IDX_W-1:0] r_col;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_row <= '0;
          r_col <= '0;
        end else if (w_start_run) begin
          r_row <= '0;
          r_col <= '0;
        end else if (w_fire[gi]) begin
          if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + IDX_W'(1);
          end else begin
            r_col <= r_col + IDX_W'(1);
          end
        end
      end
    end
  endgenerate

  assign bus.t1_en   = w_t1_fire;
  assign bus.t1_row  = g_idx[0].r_row;
  assign bus.t1_col  = g_idx[0].r_col;
  assign bus.jac_en  = w_jac_fire;
  assign bus.jac_row = g_idx[1].r_row;
  assign bus.jac_col = g_idx[1].r_col;
  assign bus.busy    = (r_state == RUN);
  assign bus.done    = r_done;

endmodule
